// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths and index type for the 8-to-3 encoder slice.
package encoder_pkg;
    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;
endpackage

// File: rtl/encoder_8_3_core.sv
// encoder_8_3_core: purely combinational 8-to-3 index encoder.
//   a     - request vector
//   idx   - index of the winning set bit (0 when a == 0)
//   any   - at least one bit of a set
//   multi - two or more bits of a set
// PRIORITY_HIGH picks the winner on multi-hot input: 1 = highest bit, 0 = lowest.
module encoder_8_3_core
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [ENC_IN_W-1:0] a,
    output enc_idx_t            idx,
    output logic                any,
    output logic                multi
);
    // Scan order makes the last matching bit win, which encodes the priority.
    always_comb begin
        idx = '0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < ENC_IN_W; i++)
                if (a[i]) idx = enc_idx_t'(i);
        end else begin
            for (int i = ENC_IN_W - 1; i >= 0; i--)
                if (a[i]) idx = enc_idx_t'(i);
        end
    end

    assign any = |a;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(a & (a - ENC_IN_W'(1)));
endmodule

// File: rtl/encoder_8_3.sv
// encoder_8_3: registered 8-to-3 binary encoder with enable.
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset, clears all outputs
//   a         - one-hot request vector
//   en        - encode enable
//   out       - registered index of the selected bit of a
//   valid     - registered, en && a != 0
//   multi_hot - registered, en && more than one bit of a set
// Outputs follow the sampling edge by exactly one cycle; no path from a/en to outputs.
module encoder_8_3
    import encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ENC_IN_W-1:0] a,
    input  logic                en,
    output enc_idx_t            out,
    output logic                valid,
    output logic                multi_hot
);
    enc_idx_t idx;
    logic     any;
    logic     multi;

    encoder_8_3_core #(
        .PRIORITY_HIGH(PRIORITY_HIGH)
    ) u_core (
        .a    (a),
        .idx  (idx),
        .any  (any),
        .multi(multi)
    );

    // idx is already 0 for a == 0, so only en needs gating for out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
        end else begin
            out       <= en ? idx : '0;
            valid     <= en & any;
            multi_hot <= en & multi;
        end
    end
endmodule

// File: tb/tb_encoder_8_3.sv
// tb_encoder_8_3: self-checking bench for encoder_8_3, both priority settings.
module tb_encoder_8_3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] a = 8'h00;
    logic       en = 1'b0;
    logic [2:0] out_hi, out_lo;
    logic       valid_hi, valid_lo, mh_hi, mh_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder_8_3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en),
        .out(out_hi), .valid(valid_hi), .multi_hot(mh_hi)
    );
    encoder_8_3 #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en),
        .out(out_lo), .valid(valid_lo), .multi_hot(mh_lo)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: index from arithmetic on the value, not a bit scan.
    function automatic int ref_idx(input logic [7:0] v, input bit high);
        int x;
        x = int'(v);
        if (x == 0) return 0;
        if (high) return $clog2(x + 1) - 1;
        return $clog2(x & (-x));
    endfunction

    task automatic chk_all(input string tag, input logic [7:0] sa, input logic se);
        int vexp, mexp;
        vexp = (se && sa != 0) ? 1 : 0;
        mexp = (se && $countones(sa) > 1) ? 1 : 0;
        chk({tag, ".out_hi"},   int'(out_hi),   se ? ref_idx(sa, 1'b1) : 0);
        chk({tag, ".out_lo"},   int'(out_lo),   se ? ref_idx(sa, 1'b0) : 0);
        chk({tag, ".valid_hi"}, int'(valid_hi), vexp);
        chk({tag, ".valid_lo"}, int'(valid_lo), vexp);
        chk({tag, ".mh_hi"},    int'(mh_hi),    mexp);
        chk({tag, ".mh_lo"},    int'(mh_lo),    mexp);
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, ".out_hi"}, int'(out_hi), 0);
        chk({tag, ".out_lo"}, int'(out_lo), 0);
        chk({tag, ".valid"},  int'(valid_hi | valid_lo), 0);
        chk({tag, ".mh"},     int'(mh_hi | mh_lo), 0);
    endtask

    // Drive away from the edge, sample 1 time unit after it.
    task automatic step(input string tag, input logic [7:0] na, input logic ne);
        @(negedge clk);
        a  = na;
        en = ne;
        @(posedge clk);
        #1;
        chk_all(tag, na, ne);
    endtask

    initial begin
        logic [7:0] ra;
        logic       re;

        // Reset while en=1, a=80 after outputs already hold a value.
        step("pre", 8'h80, 1'b1);
        chk("pre.out_hi", int'(out_hi), 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_clear("rst_async");
        @(posedge clk);
        #1;
        chk_clear("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.out", int'(out_hi), 7);
        chk("rel.valid", int'(valid_hi), 1);

        // Disabled sweep
        for (int i = 4; i < 8; i++) step("dis", 8'(1 << i), 1'b0);

        // Enabled one-hot sweep including zero
        step("zero", 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step("oh", 8'(1 << i), 1'b1);

        // Multi-hot priority
        step("mh92", 8'b1001_0010, 1'b1);
        chk("mh92.hi", int'(out_hi), 7);
        chk("mh92.lo", int'(out_lo), 1);
        step("mhff", 8'hFF, 1'b1);
        chk("mhff.hi", int'(out_hi), 7);
        chk("mhff.lo", int'(out_lo), 0);

        // Enable toggling with a held
        step("tog1", 8'h40, 1'b1);
        step("tog0", 8'h40, 1'b0);
        step("tog2", 8'h40, 1'b1);

        // Mid-run reset pulse between edges while a=08 is registered
        step("mr02", 8'h02, 1'b1);
        step("mr04", 8'h04, 1'b1);
        step("mr08", 8'h08, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_clear("mr_async");
        #1;
        rst_n = 1'b1;
        step("mr10", 8'h10, 1'b1);
        step("mr20", 8'h20, 1'b1);

        // Randomized stimulus, biased toward one-hot values
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 8'(1 << $urandom_range(0, 7));
                1:       ra = 8'h00;
                default: ra = 8'($urandom);
            endcase
            re = ($urandom_range(0, 4) != 0);
            step("rnd", ra, re);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
